// File: rtl/speed_test_controller_mc.sv
// Multi-channel speed test sequencer driven from a 64-bit control memory.
// Polls the command word, loads per-channel configs, runs a timed test on a
// channel mask, then writes checker results and a status word back.
// Optional build macro: STC_WATCHDOG_EN adds a 24-bit ARM/DRAIN watchdog.
module speed_test_controller_mc #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int TEST_PORT      = 8,
    parameter int CFG_WIDTH      = 192,
    parameter int RES_WIDTH      = 128,
    parameter int DUR_WIDTH      = 32,
    parameter int RES_BASE       = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]      mem_addr,
    output logic [63:0]                    mem_din,
    input  logic [63:0]                    mem_dout,
    input  logic [TEST_PORT-1:0]           gen_ready,
    input  logic [TEST_PORT-1:0]           check_ready,
    input  logic [TEST_PORT*RES_WIDTH-1:0] check_results,
    output logic [TEST_PORT-1:0]           start,
    output logic [TEST_PORT-1:0]           stop,
    output logic [TEST_PORT*CFG_WIDTH-1:0] port_config,
    output logic                           busy
);

    localparam int CFG_WORDS = (CFG_WIDTH + 63) / 64;
    localparam int RES_WORDS = (RES_WIDTH + 63) / 64;
    localparam int CFG_PAD   = CFG_WORDS * 64;
    localparam int RES_PAD   = RES_WORDS * 64;
    localparam int PW        = (TEST_PORT > 1) ? $clog2(TEST_PORT) : 1;

    typedef enum logic [3:0] {
        StIdle, StLoad, StArm, StStart, StRun, StStop, StDrain, StWrite, StFinStatus, StFinCmd
    } state_t;

    state_t                 state_q, state_d;
    logic [62:0]            cmd_q, cmd_d;
    logic [DUR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]          chan_q, chan_d;
    logic [2:0]             word_q, word_d;
    logic [TEST_PORT-1:0]   wr_mask_q, wr_mask_d;
    logic                   empty_q, empty_d;
    logic                   timeout_q, timeout_d;
    // High when mem_dout holds a read of addr 0 issued from IDLE.
    logic                   rd_valid_q;
    logic                   cap_valid_q, cap_valid_d;
    logic [PW-1:0]          cap_chan_q, cap_chan_d;
    logic [2:0]             cap_word_q, cap_word_d;
    logic [CFG_WIDTH-1:0]   cfg_q [TEST_PORT];

    logic [TEST_PORT-1:0]   mask;
    logic [DUR_WIDTH-1:0]   dur;
    logic [PW:0]            nxt;
    logic [TEST_PORT-1:0]   wr_m;
    logic                   go_write;
    logic [RES_WIDTH-1:0]   res_ch;
    logic [RES_PAD-1:0]     res_pad;
    logic                   wd_fire;

    assign mask = cmd_q[40 +: TEST_PORT];
    assign dur  = cmd_q[DUR_WIDTH-1:0];
    assign busy = (state_q != StIdle);

    // Lowest set bit of m at or above index from; MSB flags that one exists.
    function automatic logic [PW:0] find_from(input logic [TEST_PORT-1:0] m, input int from);
        logic [PW:0] r;
        r = '0;
        for (int i = TEST_PORT - 1; i >= 0; i--) begin
            if (m[i] && (i >= from)) r = {1'b1, PW'(i)};
        end
        return r;
    endfunction

    // Replace 64-bit word w of a channel config; bits beyond CFG_WIDTH fall off.
    function automatic logic [CFG_WIDTH-1:0] cfg_merge(input logic [CFG_WIDTH-1:0] old,
                                                       input logic [2:0] w,
                                                       input logic [63:0] d);
        logic [CFG_PAD-1:0] pad;
        int                 sh;
        sh  = int'(w) * 64;
        pad = CFG_PAD'(old);
        pad = (pad & ~(CFG_PAD'(64'hFFFF_FFFF_FFFF_FFFF) << sh)) | (CFG_PAD'(d) << sh);
        return CFG_WIDTH'(pad);
    endfunction

`ifdef STC_WATCHDOG_EN
    logic [23:0] wd_q;

    // Counts cycles spent waiting in ARM or DRAIN; restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (state_d != state_q) begin
            wd_q <= '0;
        end else if (state_q == StArm || state_q == StDrain) begin
            wd_q <= wd_q + 24'd1;
        end
    end

    assign wd_fire = (wd_q == 24'hFF_FFFF);
`else
    assign wd_fire = 1'b0;
`endif

    // Next-state, sequencing counters and memory/pulse outputs.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        chan_d      = chan_q;
        word_d      = word_q;
        wr_mask_d   = wr_mask_q;
        empty_d     = empty_q;
        timeout_d   = timeout_q;
        cap_valid_d = 1'b0;
        cap_chan_d  = chan_q;
        cap_word_d  = word_q;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_din     = '0;
        start       = '0;
        stop        = '0;
        nxt         = '0;
        wr_m        = '0;
        go_write    = 1'b0;
        res_ch      = RES_WIDTH'(check_results >> (int'(chan_q) * RES_WIDTH));
        res_pad     = RES_PAD'(res_ch);

        unique case (state_q)
            StIdle: begin
                if (rd_valid_q && mem_dout[63]) begin
                    cmd_d     = mem_dout[62:0];
                    empty_d   = 1'b0;
                    timeout_d = 1'b0;
                    wr_mask_d = '0;
                    word_d    = '0;
                    if (mem_dout[40 +: TEST_PORT] == '0) begin
                        empty_d = 1'b1;
                        state_d = StFinStatus;
                    end else begin
                        nxt     = find_from(mem_dout[40 +: TEST_PORT], 0);
                        chan_d  = nxt[PW-1:0];
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                mem_addr    = MEM_ADDR_WIDTH'(2 + int'(chan_q) * CFG_WORDS + int'(word_q));
                cap_valid_d = 1'b1;
                if (int'(word_q) == CFG_WORDS - 1) begin
                    word_d = '0;
                    nxt    = find_from(mask, int'(chan_q) + 1);
                    if (nxt[PW]) chan_d = nxt[PW-1:0];
                    else state_d = StArm;
                end else begin
                    word_d = word_q + 3'd1;
                end
            end
            StArm: begin
                if ((gen_ready & check_ready & mask) == mask) begin
                    state_d = StStart;
                end else if (wd_fire) begin
                    timeout_d = 1'b1;
                    wr_mask_d = '0;
                    state_d   = StFinStatus;
                end
            end
            StStart: begin
                start   = mask;
                cnt_d   = dur;
                state_d = StRun;
            end
            StRun: begin
                // RUN lasts max(duration, 1) cycles; the counter never wraps.
                if (cnt_q != '0) cnt_d = cnt_q - DUR_WIDTH'(1);
                if (cnt_q <= DUR_WIDTH'(1)) state_d = StStop;
            end
            StStop: begin
                stop    = mask;
                state_d = StDrain;
            end
            StDrain: begin
                if ((check_ready & mask) == mask) begin
                    wr_m     = mask;
                    go_write = 1'b1;
                end else if (wd_fire) begin
                    wr_m      = mask & check_ready;
                    timeout_d = 1'b1;
                    go_write  = 1'b1;
                end
                if (go_write) begin
                    wr_mask_d = wr_m;
                    nxt       = find_from(wr_m, 0);
                    chan_d    = nxt[PW-1:0];
                    word_d    = '0;
                    state_d   = nxt[PW] ? StWrite : StFinStatus;
                end
            end
            StWrite: begin
                mem_we   = 1'b1;
                mem_addr = MEM_ADDR_WIDTH'(RES_BASE + int'(chan_q) * RES_WORDS + int'(word_q));
                mem_din  = 64'(res_pad >> (int'(word_q) * 64));
                if (int'(word_q) == RES_WORDS - 1) begin
                    word_d = '0;
                    nxt    = find_from(wr_mask_q, int'(chan_q) + 1);
                    if (nxt[PW]) chan_d = nxt[PW-1:0];
                    else state_d = StFinStatus;
                end else begin
                    word_d = word_q + 3'd1;
                end
            end
            StFinStatus: begin
                mem_we                 = 1'b1;
                mem_addr               = MEM_ADDR_WIDTH'(1);
                mem_din[0]             = 1'b1;
                mem_din[1]             = empty_q;
                mem_din[2]             = timeout_q;
                mem_din[8 +: TEST_PORT] = wr_mask_q;
                state_d                = StFinCmd;
            end
            StFinCmd: begin
                mem_we   = 1'b1;
                mem_addr = '0;
                mem_din  = {1'b0, cmd_q};
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            cnt_q       <= '0;
            chan_q      <= '0;
            word_q      <= '0;
            wr_mask_q   <= '0;
            empty_q     <= 1'b0;
            timeout_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_chan_q  <= '0;
            cap_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            chan_q      <= chan_d;
            word_q      <= word_d;
            wr_mask_q   <= wr_mask_d;
            empty_q     <= empty_d;
            timeout_q   <= timeout_d;
            rd_valid_q  <= (state_q == StIdle);
            cap_valid_q <= cap_valid_d;
            cap_chan_q  <= cap_chan_d;
            cap_word_q  <= cap_word_d;
        end
    end

    // Config words land one cycle after their read address was issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < TEST_PORT; p++) cfg_q[p] <= '0;
        end else if (cap_valid_q) begin
            for (int p = 0; p < TEST_PORT; p++) begin
                if (cap_chan_q == PW'(p)) cfg_q[p] <= cfg_merge(cfg_q[p], cap_word_q, mem_dout);
            end
        end
    end

    for (genvar g = 0; g < TEST_PORT; g++) begin : g_cfg
        assign port_config[g*CFG_WIDTH +: CFG_WIDTH] = cfg_q[g];
    end

endmodule

// File: doc/speed_test_controller_mc.md
Name: speed_test_controller_mc

Overview:
- Parametrised successor to the fixed four-port speed test controller; sequences a multi-channel speed test from a 64-bit control memory.
- Polls a command word, loads per-channel configs into the frame generators and checkers, and runs a timed test on a channel mask: start pulse, hardware duration counter, stop pulse.
- Writes per-channel checker results and a status word back to control memory.
- Sits between the host-visible control memory and the per-port frame generator/checker pairs.

Parameters:
- MEM_ADDR_WIDTH, 10: control memory word-address width.
- TEST_PORT, 8: channel count, 1..16.
- CFG_WIDTH, 192: per-channel config width, 1..256. CFG_WORDS = ceil(CFG_WIDTH/64).
- RES_WIDTH, 128: per-channel result width, 1..256. RES_WORDS = ceil(RES_WIDTH/64).
- DUR_WIDTH, 32: test-duration counter width, at most 40.
- RES_BASE, 256: word address of the channel 0 result block.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mem_we  out  1  memory write enable
- mem_addr  out  MEM_ADDR_WIDTH  memory word address
- mem_din  out  64  memory write data
- mem_dout  in  64  memory read data; valid one cycle after mem_addr
- gen_ready  in  TEST_PORT  generator idle/ready, per channel
- check_ready  in  TEST_PORT  checker idle/results valid, per channel
- check_results  in  TEST_PORT x RES_WIDTH  checker results
- start  out  TEST_PORT  one-cycle start pulse
- stop  out  TEST_PORT  one-cycle stop pulse
- port_config  out  TEST_PORT x CFG_WIDTH  held channel config
- busy  out  1  high outside IDLE

Behaviour:
- Memory map:
  - Addr 0, command word: bit63 GO, bits[55:40] channel mask, bits[39:0] duration in cycles (upper bits above DUR_WIDTH ignored).
  - Addr 1, status word.
  - Channel p config: addr 2+p*CFG_WORDS+k, k=0..CFG_WORDS-1. Word k fills port_config bits [64k+63:64k]; excess bits are dropped.
  - Channel p result: RES_BASE+p*RES_WORDS+k, same packing, zero-extended.
- Reset values: mem_we=0, mem_addr=0, mem_din=0, start=0, stop=0, port_config=0, busy=0, FSM=IDLE, latched mask/duration=0.
- FSM states:
  - IDLE: drive addr 0 read each cycle. When mem_dout[63]=1, latch mask (bits [40+TEST_PORT-1:40]) and duration, go to LOAD.
    - Mask=0: go directly to FINISH with status bit1 (empty) set.
  - LOAD: for each set mask bit, ascending p, issue CFG_WORDS reads and capture each word one cycle after its address. Unmasked channels are skipped in 0 cycles and keep their old port_config.
  - ARM: wait until (gen_ready & check_ready & mask) == mask.
  - START: start = mask for exactly one cycle; duration counter loads the duration value.
  - RUN: counter decrements each cycle. Leave when it reaches 0.
    - Duration 0: RUN lasts 1 cycle, so the start-to-stop spacing is 2 cycles.
  - STOP: stop = mask for exactly one cycle.
  - DRAIN: wait until (check_ready & mask) == mask. Ready must be sampled no earlier than 1 cycle after stop.
  - WRITE: for each masked channel, write RES_WORDS words (mem_we=1), one per cycle.
  - FINISH:
    - Cycle 1: write status to addr 1. bit0 done=1, bit1 empty, bit2 timeout, bits[23:8] completed mask.
    - Cycle 2: write addr 0 with GO cleared and other bits as latched.
    - Then return to IDLE.
- Latched values:
  - Host changes to addr 0 after GO is latched are ignored until IDLE.
  - port_config stays stable from the end of LOAD through FINISH and after it.
- Boundary conditions:
  - start and stop are never high in the same cycle.
  - gen_ready dropping during RUN is ignored.
  - rst mid-test: all outputs return to reset values next cycle, no stop pulse, no memory write.
  - Duration all-ones: the counter does not wrap.

Optional Feature:
- Macro STC_WATCHDOG_EN.
- Defined:
  - A 24-bit watchdog counts cycles in ARM and in DRAIN, cleared on state entry.
  - At 2^24-1: from ARM, skip to FINISH with timeout=1 and completed mask=0. From DRAIN, write results only for channels whose check_ready is high, set timeout=1, and report those channels in the completed mask.
- Undefined: ARM and DRAIN wait indefinitely, and status bit2 always reads 0.

Test Plan:
- Host writes addr0 = GO|mask 0x05|duration 100 with TEST_PORT=8; all ready = 1 -> config words read for ch0 and ch2 only; start=0x05 for 1 cycle; stop=0x05 exactly 101 cycles after start; results written at 256..257 and 260..261; status = 0x0501; addr0 bit63 = 0.
- Mask 0x00 with GO -> no start/stop; status = 0x0003 written; GO cleared within 3 cycles.
- Duration 0, mask 0x01 -> stop exactly 2 cycles after start.
- check_ready[0] held low for 50 cycles after stop -> no memory writes until it rises; results then written in order.
- Assert rst in RUN -> next cycle start/stop/mem_we/busy = 0 and port_config = 0; no status write.
- STC_WATCHDOG_EN defined, gen_ready[1] = 0 permanently, mask 0x02 -> after 2^24-1 cycles status = 0x0005, no start pulse.
